uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Parametrised UART receiver with a small elastic output queue. It is the next generation of the device-side MIDI/serial input driver. It generalises the fixed 8N1 receiver to configurable clock rate, baud, data width, parity and stop bits, uses 3-sample majority voting, and reports framing, parity and overrun errors. Received words leave through a ready/valid FIFO, so downstream parsers (MIDI message decoder) can stall without losing bytes.

## Interface
- CLOCK_HZ, 50_000_000: system clock frequency.
- BAUD, 31_250: line rate; BIT_TICKS = CLOCK_HZ/BAUD (1600 at defaults), must be ≥ 8.
- DATA_BITS, 8: payload bits per word, 5..9.
- PARITY, 0: 0 none, 1 even, 2 odd.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: queue entries, power of two ≥ 2.

Ports:
- clock  in  1  system clock.
- reset  in  1  one clock; reset is synchronous and active-high.
- uart_rx  in  1  asynchronous serial line, idle high.
- data_out  out  DATA_BITS  FIFO head word; 0 when empty.
- data_valid  out  1  FIFO non-empty.
- data_ready  in  1  consumer accepts head; pop when data_valid && data_ready.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  current occupancy.
- framing_error  out  1  one-cycle pulse: a stop bit was sampled low.
- parity_error  out  1  one-cycle pulse: parity mismatch.
- overrun  out  1  one-cycle pulse: good word dropped because the FIFO was full.

## Operation
- uart_rx passes through a 2-flop synchroniser; all logic uses the synchronised value s. prev_s is a registered copy, reset to 0.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: a falling edge (prev_s=1, s=0) starts a frame and sets tick counter t=0. Because prev_s resets to 0, a line held low through reset is not a start.
- Sample k (k=0 start, 1..DATA_BITS data, then parity, then stops) is centred at c_k = BIT_TICKS/2 + k·BIT_TICKS. The bit value is the majority of s at c_k−1, c_k, c_k+1, and the decision is made at c_k+1.
- START: a majority-high start bit is a false start; return to IDLE with no flags.
- DATA: bits are shifted in LSB first.
- PARITY (skipped if PARITY=0): compare the received bit against the XOR of the data (even) or its inverse (odd). A mismatch marks the word bad and pulses parity_error.
- STOP: every stop bit must be high. Any low stop bit pulses framing_error, marks the word bad, and moves to WAIT_HIGH. WAIT_HIGH waits for s=1, then goes to IDLE.
- After the last stop decision, go directly to IDLE, which allows ½-bit resynchronisation on back-to-back frames.
- A good word is pushed at the last stop decision. If the FIFO is full and no pop occurs that cycle, the word is dropped and overrun pulses. A push and a pop in the same cycle while full both succeed, with no overrun.
- Bad words are never pushed. Both parity_error and framing_error may pulse for one frame, in different cycles.
- FIFO is first-word-fall-through with circular read/write pointers wrapping modulo FIFO_DEPTH. Pop on empty is ignored. Simultaneous push+pop leaves the count unchanged.

## Timing
- Reset values: data_out 0, data_valid 0, fifo_count 0, all error pulses 0, state IDLE, FIFO empty, prev_s 0, synchroniser flops 1.
- Reset mid-frame aborts the frame: the partial word is discarded, no flags are raised, and queued data is lost.
- Edge detect happens 2 cycles after the uart_rx transition (synchroniser).
- Push occurs at c_last+1 after edge detect. data_valid and fifo_count update the following cycle, and data_out shows the head in that same cycle.
- Error pulses assert in the cycle after the corresponding decision and last exactly 1 cycle.
- Pop: fifo_count decrements and data_out advances the cycle after the data_valid && data_ready handshake.
- Tolerates ±4% baud mismatch at BIT_TICKS ≥ 16.

## Test plan
- Defaults, send 0x90 as 8N1 → exactly one push; data_valid=1, data_out=0x90, fifo_count=1; no error pulses.
- PARITY=1, send 0x3C with parity bit 1 (wrong) → parity_error pulses once; no push, fifo_count stays 0. Then send 0x3C with parity 0 → data_out=0x3C.
- Send 0xA5 with stop bit low, holding the line low 3 bit-times → framing_error pulses once, no push, no new frame until the line returns high. Then send 0x11 → data_out=0x11.
- Idle line, 5-cycle low glitch → no state change past START, no push, no flags.
- data_ready=0, send 0x01..0x05 → FIFO holds 0x01..0x04, overrun pulses on 0x05. Then raise data_ready → pops 0x01,0x02,0x03,0x04 in order, data_valid drops.
- Assert reset during data bit 3 of 0x55, release, send 0x7E → only 0x7E is received. Back-to-back 0x00,0xFF at +3% baud → both received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Purpose: oversampling UART receiver (configurable width/parity/stops, 3-sample majority vote) feeding a small FWFT queue.
// Latency: word pushed one cycle after the last stop-bit centre (+2 cycles synchroniser); visible at data_out the cycle after the push.
// Backpressure: ready/valid output; a good word arriving while the queue is full and not popping is dropped and flagged via overrun.
module uart_rx_fifo #(
    parameter int CLOCK_HZ   = 50_000_000,
    parameter int BAUD       = 31_250,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               uart_rx,
    output logic [DATA_BITS-1:0]               data_out,
    output logic                               data_valid,
    input  logic                               data_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
    output logic                               framing_error,
    output logic                               parity_error,
    output logic                               overrun
);

    localparam int BIT_TICKS = CLOCK_HZ / BAUD;
    localparam int TW = $clog2(BIT_TICKS);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    // tick counter runs modulo one bit; the decision lands one tick after each bit centre
    localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);
    localparam logic [TW-1:0] TICK_DEC  = TW'(BIT_TICKS / 2 + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH} state_t;

    logic                 sync1_q, sync2_q, prev_s_q;
    logic [1:0]           hist_q, hist_d;
    state_t               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 bad_q, bad_d;
    logic                 ferr_q, ferr_d, perr_q, perr_d, ovr_q, ovr_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];
    logic [PW-1:0]        wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic s, maj, dec, push, pop, full, push_ok, par_exp;

    assign s       = sync2_q;
    assign maj     = (hist_q[1] & hist_q[0]) | (hist_q[1] & s) | (hist_q[0] & s);
    assign dec     = (tick_q == TICK_DEC);
    assign par_exp = (PARITY == 2) ? ~(^shreg_q) : (^shreg_q);
    assign hist_d  = {hist_q[0], s};

    // frame FSM: edge detect, per-bit majority decisions, error flags and push request
    always_comb begin
        state_d = state_q;
        tick_d  = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shreg_d = shreg_q;
        bad_d   = bad_q;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
        push    = 1'b0;
        case (state_q)
            S_IDLE: begin
                tick_d = '0;
                if (prev_s_q && !s) begin
                    state_d = S_START;
                    bad_d   = 1'b0;
                    bit_d   = '0;
                    stop_d  = 1'b0;
                end
            end
            S_START: begin
                if (dec) state_d = maj ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (dec) begin
                    shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
                    if (bit_q == BW'(DATA_BITS - 1)) begin
                        state_d = (PARITY == 0) ? S_STOP : S_PARITY;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (dec) begin
                    if (maj != par_exp) begin
                        bad_d  = 1'b1;
                        perr_d = 1'b1;
                    end
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (dec) begin
                    if (!maj) begin
                        ferr_d  = 1'b1;
                        bad_d   = 1'b1;
                        state_d = S_WAIT_HIGH;
                    end else if (stop_q == 1'(STOP_BITS - 1)) begin
                        // leave at the last stop centre so a back-to-back start edge is caught
                        state_d = S_IDLE;
                        push    = !bad_q;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // queue next-state: FWFT circular buffer, push allowed into a full queue only when popping
    always_comb begin
        pop     = (cnt_q != '0) && data_ready;
        full    = (cnt_q == CW'(FIFO_DEPTH));
        push_ok = push && (!full || pop);
        ovr_d   = push && full && !pop;
        mem_d   = mem_q;
        if (push_ok) mem_d[wr_q] = shreg_q;
        wr_d    = wr_q + PW'(push_ok);
        rd_d    = rd_q + PW'(pop);
        cnt_d   = cnt_q;
        if (push_ok && !pop)      cnt_d = cnt_q + 1'b1;
        else if (!push_ok && pop) cnt_d = cnt_q - 1'b1;
    end

    // state registers; synchroniser resets high so the idle line is not seen as a start
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            prev_s_q <= 1'b0;
            hist_q   <= 2'b11;
            state_q  <= S_IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            stop_q   <= 1'b0;
            shreg_q  <= '0;
            bad_q    <= 1'b0;
            ferr_q   <= 1'b0;
            perr_q   <= 1'b0;
            ovr_q    <= 1'b0;
            mem_q    <= '{default: '0};
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= uart_rx;
            sync2_q  <= sync1_q;
            prev_s_q <= s;
            hist_q   <= hist_d;
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            stop_q   <= stop_d;
            shreg_q  <= shreg_d;
            bad_q    <= bad_d;
            ferr_q   <= ferr_d;
            perr_q   <= perr_d;
            ovr_q    <= ovr_d;
            mem_q    <= mem_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
        end
    end

    assign data_valid    = (cnt_q != '0);
    assign data_out      = data_valid ? mem_q[rd_q] : '0;
    assign fifo_count    = cnt_q;
    assign framing_error = ferr_q;
    assign parity_error  = perr_q;
    assign overrun       = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Purpose: directed bench for uart_rx_fifo; one 8N1 instance and one 8E1 instance at 16 clocks per bit.
// Latency: checks are taken a few cycles after each frame ends, on the falling clock edge.
// Backpressure: data_ready is held low to fill the queue, then raised to drain it.
module tb_uart_rx_fifo;

    localparam int BIT  = 1600;   // nominal bit period in time units (16 clocks of 100)
    localparam int FAST = 1553;   // about +3% baud

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rx0 = 1'b1, rx1 = 1'b1;
    logic       rdy0 = 1'b0, rdy1 = 1'b0;
    logic [7:0] dout0, dout1;
    logic       dv0, dv1, fe0, fe1, pe0, pe1, ov0, ov1;
    logic [2:0] cnt0, cnt1;

    int nvec = 0;
    int nbad = 0;
    int fe0_n = 0, pe0_n = 0, ov0_n = 0, fe1_n = 0, pe1_n = 0, ov1_n = 0;

    uart_rx_fifo #(.CLOCK_HZ(500_000), .BAUD(31_250), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_rx0 (
        .clock(clock), .reset(reset), .uart_rx(rx0), .data_out(dout0), .data_valid(dv0),
        .data_ready(rdy0), .fifo_count(cnt0), .framing_error(fe0), .parity_error(pe0),
        .overrun(ov0));

    uart_rx_fifo #(.CLOCK_HZ(500_000), .BAUD(31_250), .DATA_BITS(8), .PARITY(1),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_rx1 (
        .clock(clock), .reset(reset), .uart_rx(rx1), .data_out(dout1), .data_valid(dv1),
        .data_ready(rdy1), .fifo_count(cnt1), .framing_error(fe1), .parity_error(pe1),
        .overrun(ov1));

    always #50 clock = ~clock;

    // count every cycle each error output is high
    always @(negedge clock) begin
        if (fe0) fe0_n++;
        if (pe0) pe0_n++;
        if (ov0) ov0_n++;
        if (fe1) fe1_n++;
        if (pe1) pe1_n++;
        if (ov1) ov1_n++;
    end

    task automatic check(input string tag, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nbad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic setl(input int ln, input logic v);
        if (ln == 0) rx0 = v;
        else         rx1 = v;
    endtask

    // one frame: start, LSB-first data, optional parity bit (par<0 = none), stop level held 'hold' bits
    task automatic send(input int ln, input logic [8:0] d, input int nd, input int par,
                        input logic stp, input int hold, input int per);
        @(posedge clock);
        #1;
        setl(ln, 1'b0);
        #per;
        for (int i = 0; i < nd; i++) begin
            setl(ln, d[i]);
            #per;
        end
        if (par >= 0) begin
            setl(ln, par[0]);
            #per;
        end
        setl(ln, stp);
        #(per * hold);
        setl(ln, 1'b1);
    endtask

    task automatic settle();
        repeat (4) @(negedge clock);
    endtask

    task automatic pop0();
        @(posedge clock);
        #1 rdy0 = 1'b1;
        @(posedge clock);
        #1 rdy0 = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_dout", dout0, 0);
        check("rst_valid", dv0, 0);
        check("rst_count", cnt0, 0);
        check("rst_errs", {fe0, pe0, ov0}, 0);
        #1 reset = 1'b0;
        repeat (5) @(negedge clock);
        check("idle_count", cnt1, 0);

        // plain 8N1 word
        send(0, 9'h090, 8, -1, 1'b1, 1, BIT);
        settle();
        check("w90_valid", dv0, 1);
        check("w90_dout", dout0, 8'h90);
        check("w90_count", cnt0, 1);
        check("w90_errs", fe0_n + pe0_n + ov0_n, 0);
        pop0();
        check("w90_pop_count", cnt0, 0);
        check("w90_pop_dout", dout0, 0);

        // stop bit low, line kept low for 3 bit-times
        send(0, 9'h0A5, 8, -1, 1'b0, 3, BIT);
        settle();
        check("fr_ferr", fe0_n, 1);
        check("fr_count", cnt0, 0);
        #BIT;
        send(0, 9'h011, 8, -1, 1'b1, 1, BIT);
        settle();
        check("fr_next_dout", dout0, 8'h11);
        check("fr_next_count", cnt0, 1);
        check("fr_next_ferr", fe0_n, 1);
        pop0();

        // 5-cycle low glitch is a false start
        @(posedge clock);
        #1 rx0 = 1'b0;
        #500 rx0 = 1'b1;
        repeat (200) @(negedge clock);
        check("gl_count", cnt0, 0);
        check("gl_flags", fe0_n * 16 + pe0_n * 4 + ov0_n, 16);

        // fill the queue with backpressure, fifth word overruns
        for (int i = 1; i <= 5; i++) send(0, 9'(i), 8, -1, 1'b1, 1, BIT);
        settle();
        check("ov_count", cnt0, 4);
        check("ov_pulse", ov0_n, 1);
        check("ov_head", dout0, 8'h01);
        @(posedge clock);
        #1 rdy0 = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock);
            check("ov_drain", dout0, i);
        end
        @(negedge clock);
        check("ov_empty_valid", dv0, 0);
        check("ov_empty_count", cnt0, 0);
        #1 rdy0 = 1'b0;

        // even parity: 0x3C has four ones, so the parity bit must be 0
        send(1, 9'h03C, 8, 1, 1'b1, 1, BIT);
        settle();
        check("par_bad_perr", pe1_n, 1);
        check("par_bad_count", cnt1, 0);
        #BIT;
        send(1, 9'h03C, 8, 0, 1'b1, 1, BIT);
        settle();
        check("par_ok_dout", dout1, 8'h3C);
        check("par_ok_count", cnt1, 1);
        check("par_ok_perr", pe1_n, 1);
        check("par_ok_ferr", fe1_n, 0);

        // back-to-back frames at +3% baud
        send(0, 9'h000, 8, -1, 1'b1, 1, FAST);
        send(0, 9'h0FF, 8, -1, 1'b1, 1, FAST);
        settle();
        check("b2b_count", cnt0, 2);
        check("b2b_first", dout0, 8'h00);
        check("b2b_ferr", fe0_n, 1);
        pop0();
        check("b2b_second", dout0, 8'hFF);

        // reset in the middle of data bit 3 of 0x55, released while the line is high
        @(posedge clock);
        #1 rx0 = 1'b0;
        #BIT;
        for (int i = 0; i < 8; i++) begin
            rx0 = (i % 2 == 0) ? 1'b1 : 1'b0;
            if (i == 3) begin
                #(BIT / 2) reset = 1'b1;
                #(BIT / 2);
            end else begin
                #BIT;
            end
        end
        rx0 = 1'b1;
        #(BIT / 2) reset = 1'b0;
        @(negedge clock);
        check("rst_mid_count", cnt0, 0);
        check("rst_mid_dout", dout0, 0);
        check("rst_mid_q1", cnt1, 0);
        #BIT;
        send(0, 9'h07E, 8, -1, 1'b1, 1, BIT);
        settle();
        check("rst_7e_dout", dout0, 8'h7E);
        check("rst_7e_count", cnt0, 1);
        check("rst_7e_flags", fe0_n * 16 + pe0_n * 4 + ov0_n, 17);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
